bus_word_sequencer: RTL

Controller that accepts one BUS_SIZE-bit packet at a time through a valid/ready handshake. It checks the packet's header word and, if the header is good, sequences the remaining payload words out one per beat, MSB word first, under downstream backpressure. It sits between the bus source and the word-level datapath, and it is the only block that drives that datapath's word stream and error flag.

---
 rtl/bus_word_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bus_word_sequencer.sv
// bus_word_sequencer: accepts one BUS_SIZE-bit packet over valid/ready, checks
// the header word and streams the payload words out MSB word first under
// downstream backpressure. All outputs are registered.
// Optional build macro SEQ_ERR_CNT_EN adds the saturating err_cnt output.
module bus_word_sequencer #(
    parameter int unsigned           BUS_SIZE  = 16,
    parameter int unsigned           WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0]  HEADER    = {WORD_SIZE{1'b1}},
    localparam int unsigned          WORD_NUM  = BUS_SIZE / WORD_SIZE,
    localparam int unsigned          IDX_W     = $clog2(WORD_NUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE-1:0]  data_input,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 word_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     word_idx,
    output logic                 word_last,
    output logic                 err,
    output logic                 busy
`ifdef SEQ_ERR_CNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    localparam int unsigned PAY_W = BUS_SIZE - WORD_SIZE;

    typedef enum logic [1:0] {StIdle, StSend, StError} state_e;

    state_e               state_q, state_d;
    logic [PAY_W-1:0]     pay_q, pay_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 header_ok;
    logic [PAY_W-1:0]     pay_shift;

    assign accept    = in_valid && in_ready_q;
    assign header_ok = (data_input[BUS_SIZE-1 -: WORD_SIZE] == HEADER);
    // Payload is kept left-aligned; the current word is always the top slice.
    assign pay_shift = pay_q << WORD_SIZE;

    // State and output registers; reset discards any packet in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pay_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pay_q      <= pay_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below
    always_comb begin
        state_d    = state_q;
        pay_d      = pay_q;
        word_d     = word_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        err_d      = err_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;

        unique case (state_q)
            StIdle, StError: begin
                if (accept) begin
                    busy_d = 1'b1;
                    if (header_ok) begin
                        state_d    = StSend;
                        pay_d      = data_input[PAY_W-1:0];
                        word_d     = data_input[PAY_W-1 -: WORD_SIZE];
                        idx_d      = IDX_W'(WORD_NUM - 2);
                        valid_d    = 1'b1;
                        last_d     = (WORD_NUM == 2);
                        err_d      = 1'b0;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end
                end
            end
            StSend: begin
                if (valid_q && out_ready) begin
                    if (idx_q == '0) begin
                        state_d    = StIdle;
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        pay_d  = pay_shift;
                        word_d = pay_shift[PAY_W-1 -: WORD_SIZE];
                        idx_d  = idx_q - IDX_W'(1);
                        last_d = (idx_q == IDX_W'(1));
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_ready   = in_ready_q;
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign word_idx   = idx_q;
    assign word_last  = last_q;
    assign err        = err_q;
    assign busy       = busy_q;

`ifdef SEQ_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of rejected packets; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'h00;
        end else if (accept && !header_ok && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Counter absent in this build.
`endif

endmodule
